// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with registered read ports, load
// extraction, store lane replication and a busy scoreboard. Optional: REGFILE_SB_BYPASS_EN.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREGS),
    localparam int OW   = $clog2(XLEN / 8)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic [1:0]              st_size,
    output logic [XLEN-1:0]         st_data,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [XLEN-1:0]         wr_data,
    input  logic [1:0]              wr_size,
    input  logic                    wr_unsigned,
    input  logic [OW-1:0]           wr_offset,
    input  logic                    mark_en,
    input  logic [AW-1:0]           mark_addr
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    // With a single read port the store source falls back to port 0.
    localparam int ST_PORT = (NREAD > 1) ? 1 : 0;

    logic [XLEN-1:0]        regs [NREGS];
    logic [NREGS-1:0]       busy;
    logic [NREGS-1:0]       busy_nxt;

    logic                   wr_live;
    logic                   mark_live;
    logic [XLEN-1:0]        field;
    logic [XLEN-1:0]        wb_val;

    logic [XLEN-1:0]        port_val [NREAD];
    logic [NREAD-1:0]       port_busy;
    logic [NREAD*XLEN-1:0]  rd_data_nxt;
    logic [XLEN-1:0]        st_src;
    logic [XLEN-1:0]        st_nxt;

    assign wr_live   = wr_en && (wr_addr != '0);
    assign mark_live = mark_en && (mark_addr != '0);

    // Load write-back extraction: shift the addressed byte lane down, then extend.
    always_comb begin
        field  = wr_data >> {wr_offset, 3'b000};
        wb_val = wr_data;
        case (wr_size)
            SZ_BYTE: begin
                if (wr_unsigned)
                    wb_val = XLEN'(field[7:0]);
                else
                    wb_val = XLEN'($signed(field[7:0]));
            end
            SZ_HALF: begin
                if (wr_unsigned)
                    wb_val = XLEN'(field[15:0]);
                else
                    wb_val = XLEN'($signed(field[15:0]));
            end
            SZ_WORD: begin
                if (XLEN > 32) begin
                    if (wr_unsigned)
                        wb_val = XLEN'(field[31:0]);
                    else
                        wb_val = XLEN'($signed(field[31:0]));
                end
            end
            default: wb_val = wr_data;
        endcase
    end

    // Scoreboard update: write clears, mark sets, mark applied last so it wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_live)
            busy_nxt[wr_addr] = 1'b0;
        if (mark_live)
            busy_nxt[mark_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        rd_data_nxt = '0;
        port_busy   = '0;
        for (int i = 0; i < NREAD; i++) begin
            port_val[i]  = regs[rd_addr[i*AW +: AW]];
            port_busy[i] = busy[rd_addr[i*AW +: AW]];
`ifdef REGFILE_SB_BYPASS_EN
            if (wr_live && (wr_addr == rd_addr[i*AW +: AW]))
                port_val[i] = wb_val;
            port_busy[i] = busy_nxt[rd_addr[i*AW +: AW]];
`endif
            if (rd_addr[i*AW +: AW] == '0) begin
                port_val[i]  = '0;
                port_busy[i] = 1'b0;
            end
            rd_data_nxt[i*XLEN +: XLEN] = port_val[i];
        end
    end

    always_comb begin
        st_src = port_val[ST_PORT];
        case (st_size)
            SZ_BYTE: st_nxt = {(XLEN/8){st_src[7:0]}};
            SZ_HALF: st_nxt = {(XLEN/16){st_src[15:0]}};
            SZ_WORD: st_nxt = {(XLEN/32){st_src[31:0]}};
            default: st_nxt = st_src;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
            busy    <= '0;
            rd_data <= '0;
            rd_busy <= '0;
            st_data <= '0;
        end else begin
            if (wr_live)
                regs[wr_addr] <= wb_val;
            busy    <= busy_nxt;
            rd_data <= rd_data_nxt;
            rd_busy <= port_busy;
            st_data <= st_nxt;
        end
    end

endmodule
